// File: rtl/scope_pkg.sv
// Shared definitions for the scope datapath: default widths, the
// decimator mode encoding and a signed saturation helper.
package scope_pkg;

    localparam int SCOPE_DCW = 17;
    localparam int SCOPE_SHW = 5;
    localparam int SAT_W     = 64;

    typedef enum logic {
        MODE_KEEP = 1'b0,
        MODE_AVG  = 1'b1
    } dec_mode_e;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle; the clock and reset travel with the stream.
interface axi4_stream_if #(
    parameter int DN = 1,
    parameter int DW = 14
) (
    input logic ACLK,
    input logic ARESETn
);
    localparam int KW = (DN * DW + 7) / 8;

    logic [DN*DW-1:0] TDATA;
    logic [KW-1:0]    TKEEP;
    logic             TLAST;
    logic             TVALID;
    logic             TREADY;

    modport d (input ACLK, ARESETn, TDATA, TKEEP, TLAST, TVALID, output TREADY);
    modport s (input ACLK, ARESETn, TREADY, output TDATA, TKEEP, TLAST, TVALID);
endinterface

// File: rtl/scope_decimator.sv
// Decimates a sample stream by N, emitting either the saturated, shifted
// sum of each group of N samples or the last sample of each group.
module scope_decimator
    import scope_pkg::*;
#(
    parameter int DN  = 1,
    parameter int DWI = 14,
    parameter int DWO = 14,
    parameter int DCW = SCOPE_DCW
) (
    input  logic                 ctl_rst,
    input  logic [DCW-1:0]       cfg_dec,
    input  logic [SCOPE_SHW-1:0] cfg_shr,
    input  logic                 cfg_avg,
    axi4_stream_if.d             sti,
    axi4_stream_if.s             sto
);

    localparam int AW = DWI + DCW;

    logic                    clk;
    logic [DCW-1:0]          cnt_r;
    logic signed [AW-1:0]    acc_r;
    logic [DWO-1:0]          tdata_r;
    logic                    tvalid_r;

    logic [DCW-1:0]          n_s;
    logic                    ready_s;
    logic                    xfer_s;
    logic                    last_s;
    logic signed [DWI-1:0]   sample_s;
    logic signed [AW-1:0]    sample_ext_s;
    logic signed [AW-1:0]    sum_s;
    logic signed [AW-1:0]    res_s;
    logic signed [SAT_W-1:0] wide_s;
    logic signed [SAT_W-1:0] sat_s;
    logic                    unused_ok;

    assign clk       = sti.ACLK;
    assign unused_ok = ^{sti.ARESETn, sti.TLAST, sti.TKEEP, DN[0]};

    // The upstream may only push when the output register is free or draining.
    assign ready_s    = sto.TREADY | ~tvalid_r;
    assign sti.TREADY = ready_s;
    assign xfer_s     = sti.TVALID & ready_s;
    assign sample_s   = sti.TDATA[DWI-1:0];

    // Group bookkeeping, accumulation and result formatting.
    always_comb begin
        n_s          = {DCW{1'b0}};
        last_s       = 1'b0;
        sample_ext_s = {{DCW{sample_s[DWI-1]}}, sample_s};
        sum_s        = {AW{1'b0}};
        res_s        = {AW{1'b0}};
        wide_s       = {SAT_W{1'b0}};
        sat_s        = {SAT_W{1'b0}};

        if (cfg_dec == {DCW{1'b0}}) begin
            n_s = {{(DCW-1){1'b0}}, 1'b1};
        end else begin
            n_s = cfg_dec;
        end
        // A shrunk N mid-group makes the very next transfer the last one.
        last_s = (cnt_r >= (n_s - {{(DCW-1){1'b0}}, 1'b1}));

        if (cnt_r == {DCW{1'b0}}) begin
            sum_s = sample_ext_s;
        end else begin
            sum_s = acc_r + sample_ext_s;
        end

        case (dec_mode_e'(cfg_avg))
            MODE_AVG:  res_s = sum_s >>> cfg_shr;
            MODE_KEEP: res_s = sample_ext_s;
            default:   res_s = sample_ext_s;
        endcase

        wide_s = {{(SAT_W-AW){res_s[AW-1]}}, res_s};
        sat_s  = sat_signed(wide_s, DWO);
    end

    // Group counter, accumulator and registered output stage.
    always_ff @(posedge clk) begin
        if (ctl_rst) begin
            cnt_r    <= {DCW{1'b0}};
            acc_r    <= {AW{1'b0}};
            tvalid_r <= 1'b0;
            tdata_r  <= {DWO{1'b0}};
        end else begin
            if (xfer_s) begin
                acc_r <= sum_s;
                if (last_s) begin
                    cnt_r <= {DCW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + {{(DCW-1){1'b0}}, 1'b1};
                end
            end
            if (xfer_s && last_s) begin
                tvalid_r <= 1'b1;
                tdata_r  <= sat_s[DWO-1:0];
            end else if (sto.TREADY) begin
                tvalid_r <= 1'b0;
            end
        end
    end

    assign sto.TDATA  = tdata_r;
    assign sto.TVALID = tvalid_r;
    assign sto.TLAST  = 1'b0;
    assign sto.TKEEP  = '1;

endmodule

// File: tb/tb_scope_decimator.sv
// Self-checking bench for scope_decimator: directed scenarios followed by
// random traffic, all compared against a group-level reference model.
module tb_scope_decimator;

    localparam int DCW = 17;
    localparam int DW  = 14;

    logic           clk = 1'b0;
    logic           ctl_rst;
    logic [DCW-1:0] cfg_dec;
    logic [4:0]     cfg_shr;
    logic           cfg_avg;

    always #5 clk = ~clk;

    axi4_stream_if #(.DN(1), .DW(DW)) sti (.ACLK(clk), .ARESETn(1'b1));
    axi4_stream_if #(.DN(1), .DW(DW)) sto (.ACLK(clk), .ARESETn(1'b1));

    scope_decimator #(.DN(1), .DWI(DW), .DWO(DW), .DCW(DCW)) dut (
        .ctl_rst (ctl_rst),
        .cfg_dec (cfg_dec),
        .cfg_shr (cfg_shr),
        .cfg_avg (cfg_avg),
        .sti     (sti),
        .sto     (sto)
    );

    int     n_checks = 0;
    int     n_fails  = 0;
    int     exp_q[$];
    int     obs_q[$];
    int     cnt_m    = 0;
    longint sum_m    = 0;
    bit     after_rst = 1'b1;
    bit     fired    = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat14(input longint v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return int'(v);
    endfunction

    // One clock: check outputs before the edge, then advance the model.
    task automatic step();
        bit       in_fire;
        bit       out_fire;
        bit       rst;
        int       od;
        longint   x;
        int       n;
        bit       avg;
        int       shr;
        #2;
        chk("sto_valid", sto.TVALID, (exp_q.size() != 0) ? 1 : 0);
        chk("sti_ready", sti.TREADY, (sto.TREADY || exp_q.size() == 0) ? 1 : 0);
        if (exp_q.size() != 0) chk("sto_data", $signed(sto.TDATA), exp_q[0]);
        else if (after_rst)    chk("sto_data_rst", $signed(sto.TDATA), 0);
        in_fire  = sti.TVALID && (exp_q.size() == 0 || sto.TREADY);
        out_fire = (exp_q.size() != 0) && sto.TREADY;
        rst      = ctl_rst;
        od       = $signed(sto.TDATA);
        x        = longint'($signed(sti.TDATA));
        n        = (cfg_dec == 0) ? 1 : int'(cfg_dec);
        avg      = cfg_avg;
        shr      = int'(cfg_shr);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            cnt_m     = 0;
            sum_m     = 0;
            after_rst = 1'b1;
            fired     = 1'b0;
        end else begin
            if (out_fire) begin
                obs_q.push_back(od);
                void'(exp_q.pop_front());
            end
            fired = in_fire;
            if (in_fire) begin
                sum_m = (cnt_m == 0) ? x : sum_m + x;
                if (cnt_m >= n - 1) begin
                    exp_q.push_back(avg ? sat14(sum_m >>> shr) : int'(x));
                    cnt_m     = 0;
                    after_rst = 1'b0;
                end else begin
                    cnt_m++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input int x);
        sti.TVALID = 1'b1;
        sti.TDATA  = 14'(x);
        for (int i = 0; i < 20; i++) begin
            step();
            if (fired) break;
        end
        chk("send_accepted", fired, 1);
        sti.TVALID = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cfg(input int dec, input int shr, input bit avg);
        cfg_dec = DCW'(dec);
        cfg_shr = 5'(shr);
        cfg_avg = avg;
        obs_q.delete();
    endtask

    initial begin
        int     t0;
        int     cycles;
        bit     cur_v;
        int     r;
        int     s;

        ctl_rst    = 1'b1;
        cfg_dec    = 17'd4;
        cfg_shr    = 5'd0;
        cfg_avg    = 1'b1;
        sti.TVALID = 1'b0;
        sti.TDATA  = 14'd0;
        sti.TKEEP  = 2'b11;
        sti.TLAST  = 1'b0;
        sto.TREADY = 1'b1;
        repeat (2) @(negedge clk);
        idle(2);
        chk("rst_sti_ready", sti.TREADY, 1);
        ctl_rst = 1'b0;
        chk("tlast", sto.TLAST, 0);
        chk("tkeep", sto.TKEEP, 3);

        // Average of four samples shifted by two.
        set_cfg(4, 2, 1'b1);
        send(10); send(20); send(30); send(40);
        idle(2);
        chk("avg_count", obs_q.size(), 1);
        chk("avg_value", obs_q[0], 25);

        // Keep mode, groups of three.
        set_cfg(3, 3, 1'b0);
        for (int i = 1; i <= 9; i++) send(i);
        idle(2);
        chk("keep_count", obs_q.size(), 3);
        chk("keep_v0", obs_q[0], 3);
        chk("keep_v1", obs_q[1], 6);
        chk("keep_v2", obs_q[2], 9);

        // Saturation at both rails.
        set_cfg(4, 0, 1'b1);
        for (int i = 0; i < 4; i++) send(8191);
        for (int i = 0; i < 4; i++) send(-8192);
        idle(2);
        chk("sat_count", obs_q.size(), 2);
        chk("sat_hi", obs_q[0], 8191);
        chk("sat_lo", obs_q[1], -8192);

        // Backpressure with N=1.
        set_cfg(1, 0, 1'b0);
        sto.TREADY = 1'b0;
        send(7);
        sti.TVALID = 1'b1;
        sti.TDATA  = 14'd8;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_sti_ready", sti.TREADY, 0);
            chk("bp_hold", $signed(sto.TDATA), 7);
        end
        sto.TREADY = 1'b1;
        send(8);
        send(9);
        idle(2);
        chk("bp_count", obs_q.size(), 3);
        chk("bp_v0", obs_q[0], 7);
        chk("bp_v1", obs_q[1], 8);
        chk("bp_v2", obs_q[2], 9);

        // Reset in the middle of a group discards the partial sum.
        set_cfg(4, 0, 1'b1);
        send(100); send(100);
        ctl_rst = 1'b1;
        step();
        chk("rst_mid_ready", sti.TREADY, 1);
        ctl_rst = 1'b0;
        send(1); send(2); send(3); send(4);
        idle(2);
        chk("rst_mid_count", obs_q.size(), 1);
        chk("rst_mid_value", obs_q[0], 10);

        // cfg_dec of zero acts as one, at full throughput.
        set_cfg(0, 0, 1'b1);
        t0 = int'($time);
        send(5);
        send(-5);
        cycles = (int'($time) - t0) / 10;
        chk("dec0_cycles", cycles, 2);
        idle(2);
        chk("dec0_count", obs_q.size(), 2);
        chk("dec0_v0", obs_q[0], 5);
        chk("dec0_v1", obs_q[1], -5);

        // Shrinking N mid-group closes the group on the next transfer.
        set_cfg(4, 0, 1'b1);
        send(1); send(2);
        cfg_dec = 17'd2;
        send(4);
        idle(2);
        chk("shrink_count", obs_q.size(), 1);
        chk("shrink_value", obs_q[0], 7);

        // Random traffic with random backpressure and occasional resets.
        cur_v = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (cnt_m == 0 && $urandom_range(0, 7) == 0) begin
                cfg_dec = DCW'($urandom_range(0, 5));
                cfg_shr = 5'($urandom_range(0, 3));
                cfg_avg = 1'($urandom_range(0, 1));
            end
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 3) != 0);
                r = int'($urandom_range(0, 9));
                if (r == 0)      s = 8191;
                else if (r == 1) s = -8192;
                else             s = int'($urandom_range(0, 16383)) - 8192;
                sti.TDATA = 14'(s);
            end
            sti.TVALID = cur_v;
            sto.TREADY = ($urandom_range(0, 3) != 0);
            ctl_rst    = ($urandom_range(0, 99) == 0);
            step();
            if (fired) cur_v = 1'b0;
        end
        ctl_rst    = 1'b0;
        sti.TVALID = 1'b0;
        sto.TREADY = 1'b1;
        idle(3);
        chk("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
